// File: rtl/reg_cmd_master_if.sv
// Command, register-bus and read-response signals of reg_cmd_master.
// master = the command stage itself, slave = the surrounding environment.
interface reg_cmd_master_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  sel;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  busy;
  logic                  err_timeout;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rdata, ready, rsp_ready,
    output cmd_ready, sel, wr, addr, wdata, rsp_valid, rsp_addr, rsp_data,
           rsp_err, busy, err_timeout
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rdata, ready, rsp_ready,
    input  cmd_ready, sel, wr, addr, wdata, rsp_valid, rsp_addr, rsp_data,
           rsp_err, busy, err_timeout
  );
endinterface

// File: rtl/reg_cmd_master.sv
// Buffers register commands in a small FIFO and issues them one at a time on
// the controller's sel/wr bus; read data returns on a valid/ready port.
module reg_cmd_master #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic              clk,
  input logic              rst,
  reg_cmd_master_if.master bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, RSP} state_e;

  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  entry_t                head;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop, cmd_ready;

  state_e                state_q, state_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  sel_q, sel_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic                  err_q, err_d;

  assign cmd_ready = (count_q < CW'(DEPTH));

  always_comb begin
    push    = bus.cmd_valid && cmd_ready;
    pop     = (state_q == IDLE) && (count_q != '0);
    head    = mem_q[rptr_q];
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = {bus.cmd_wr, bus.cmd_addr, bus.cmd_wdata};
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    sel_d       = sel_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (pop) begin
          sel_d   = 1'b1;
          wr_d    = head.wr;
          addr_d  = head.addr;
          wdata_d = head.wdata;
          state_d = REQ;
        end
      end
      // REQ and RDWAIT share one stall budget; the counter only clears in IDLE.
      REQ, RDWAIT: begin
        if (bus.ready) begin
          if (state_q == REQ) begin
            sel_d   = 1'b0;
            wr_d    = 1'b0;
            state_d = wr_q ? IDLE : RDWAIT;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = addr_q;
            rsp_data_d  = bus.rdata;
            rsp_err_d   = 1'b0;
            state_d     = RSP;
          end
        end else if (tcnt_q >= TW'(TIMEOUT - 1)) begin
          tcnt_d = TW'(TIMEOUT);
          sel_d  = 1'b0;
          wr_d   = 1'b0;
          err_d  = 1'b1;
          if (wr_q) begin
            state_d = IDLE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = addr_q;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            state_d     = RSP;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      tcnt_q      <= '0;
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.sel         = sel_q;
  assign bus.wr          = wr_q;
  assign bus.addr        = addr_q;
  assign bus.wdata       = wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_addr    = rsp_addr_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.busy        = (count_q != '0) || (state_q != IDLE);
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_reg_cmd_master.sv
// Bench for reg_cmd_master: directed scenarios plus random traffic, checked
// against a command queue / register-file model of the controller.
module tb_reg_cmd_master;
  localparam int unsigned AW      = 8;
  localparam int unsigned DW      = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  typedef enum int {RDY_MANUAL, RDY_RDLOW, RDY_RAND} rdy_mode_e;
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int unsigned   checks = 0;
  int unsigned   errors = 0;
  cmd_t          exp_cmds[$];
  rsp_t          exp_rsps[$];
  logic [DW-1:0] regs [256];
  logic          exp_err = 1'b0;
  int unsigned   wait_cnt = 0;
  rdy_mode_e     rdy_mode = RDY_MANUAL;

  reg_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  reg_cmd_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int unsigned n;
    n = 0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_wr    = w;
    ifc.cmd_addr  = a;
    ifc.cmd_wdata = d;
    forever begin
      @(negedge clk);
      if (ifc.cmd_ready) break;
      n++;
      if (n > 200) begin
        check("push_accept_timeout", ifc.cmd_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    forever begin
      tick(1);
      if (!ifc.busy && !ifc.rsp_valid && exp_cmds.size() == 0) break;
      n++;
      if (n > 500) begin
        check("idle_wait_timeout", ifc.busy, 0);
        break;
      end
    end
  endtask

  // Controller model: returns register contents and shapes ready.
  initial begin : controller
    int unsigned lows;
    logic        rd_acc;
    lows = 0;
    forever begin
      @(negedge clk);
      rd_acc = ifc.sel && ifc.ready && !ifc.wr;
      @(posedge clk);
      #1;
      ifc.rdata = regs[ifc.addr];
      case (rdy_mode)
        RDY_RDLOW: ifc.ready = !rd_acc;
        RDY_RAND: begin
          if (lows >= 3 || $urandom_range(0, 2) != 0) begin
            ifc.ready = 1'b1;
            lows = 0;
          end else begin
            ifc.ready = 1'b0;
            lows++;
          end
          ifc.rsp_ready = ($urandom_range(0, 1) == 1);
        end
        default: ;
      endcase
    end
  end

  // Reference model: commands leave in push order, reads return register contents.
  initial begin : monitor
    cmd_t c;
    rsp_t r;
    logic aborted;
    aborted = 1'b0;
    forever begin
      @(negedge clk);
      check("err_timeout", ifc.err_timeout, exp_err);
      if (rst) begin
        exp_cmds.delete();
        exp_rsps.delete();
        exp_err  = 1'b0;
        wait_cnt = 0;
        aborted  = 1'b0;
      end else begin
        if (aborted) begin
          check("timeout_sel_drop", ifc.sel, 0);
          aborted = 1'b0;
        end
        if (ifc.sel) begin
          if (exp_cmds.size() == 0) begin
            check("bus_has_pending_cmd", exp_cmds.size() != 0, 1);
          end else if (ifc.ready) begin
            c = exp_cmds.pop_front();
            check("bus_wr", ifc.wr, c.wr);
            check("bus_addr", ifc.addr, c.addr);
            if (c.wr) begin
              check("bus_wdata", ifc.wdata, c.data);
              regs[c.addr] = c.data;
            end else begin
              exp_rsps.push_back('{addr: c.addr, data: regs[c.addr], err: 1'b0});
            end
            wait_cnt = 0;
          end else begin
            wait_cnt++;
            if (wait_cnt == TIMEOUT) begin
              c = exp_cmds.pop_front();
              check("abort_addr", ifc.addr, c.addr);
              if (!c.wr) exp_rsps.push_back('{addr: c.addr, data: '0, err: 1'b1});
              exp_err  = 1'b1;
              aborted  = 1'b1;
              wait_cnt = 0;
            end
          end
        end else begin
          wait_cnt = 0;
        end
        if (ifc.cmd_valid && ifc.cmd_ready) begin
          exp_cmds.push_back('{wr: ifc.cmd_wr, addr: ifc.cmd_addr, data: ifc.cmd_wdata});
        end
        if (ifc.rsp_valid && ifc.rsp_ready) begin
          if (exp_rsps.size() == 0) begin
            check("rsp_has_pending_read", exp_rsps.size() != 0, 1);
          end else begin
            r = exp_rsps.pop_front();
            check("rsp_addr", ifc.rsp_addr, r.addr);
            check("rsp_data", ifc.rsp_data, r.data);
            check("rsp_err", ifc.rsp_err, r.err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned   n_sel;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_wr    = 1'b0;
    ifc.cmd_addr  = '0;
    ifc.cmd_wdata = '0;
    ifc.rdata     = '0;
    ifc.ready     = 1'b1;
    ifc.rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) regs[i] = '0;

    tick(3);
    check("rst_cmd_ready", ifc.cmd_ready, 1);
    check("rst_sel", ifc.sel, 0);
    check("rst_wr", ifc.wr, 0);
    check("rst_addr", ifc.addr, 0);
    check("rst_wdata", ifc.wdata, 0);
    check("rst_rsp_valid", ifc.rsp_valid, 0);
    check("rst_rsp_addr", ifc.rsp_addr, 0);
    check("rst_rsp_data", ifc.rsp_data, 0);
    check("rst_rsp_err", ifc.rsp_err, 0);
    check("rst_busy", ifc.busy, 0);
    rst = 1'b0;

    // Single write, ready high throughout.
    push_cmd(1'b1, 8'h10, 16'hABCD);
    check("wr_sel_latency", ifc.sel, 0);
    tick(1);
    check("wr_sel", ifc.sel, 1);
    check("wr_wr", ifc.wr, 1);
    check("wr_addr", ifc.addr, 32'h10);
    check("wr_wdata", ifc.wdata, 32'hABCD);
    check("wr_busy", ifc.busy, 1);
    tick(1);
    check("wr_sel_pulse", ifc.sel, 0);
    check("wr_busy_done", ifc.busy, 0);

    // Read with one ready-low cycle after accept; response held 5 cycles.
    rdy_mode = RDY_RDLOW;
    push_cmd(1'b0, 8'h10, 16'h0);
    tick(1);
    check("rd_sel", ifc.sel, 1);
    check("rd_wr", ifc.wr, 0);
    tick(2);
    check("rd_rsp_early", ifc.rsp_valid, 0);
    tick(1);
    check("rd_rsp_valid", ifc.rsp_valid, 1);
    check("rd_rsp_addr", ifc.rsp_addr, 32'h10);
    check("rd_rsp_data", ifc.rsp_data, 32'hABCD);
    check("rd_rsp_err", ifc.rsp_err, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("rd_rsp_hold_valid", ifc.rsp_valid, 1);
      check("rd_rsp_hold_data", ifc.rsp_data, 32'hABCD);
    end
    ifc.rsp_ready = 1'b1;
    tick(1);
    check("rd_rsp_done", ifc.rsp_valid, 0);

    // Fill: DEPTH+1 accepted while the bus stalls.
    rdy_mode  = RDY_MANUAL;
    ifc.ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 7));
      d = DW'($urandom);
      push_cmd(w, a, d);
    end
    check("full_cmd_ready", ifc.cmd_ready, 0);
    check("full_busy", ifc.busy, 1);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_wr    = 1'b1;
    ifc.cmd_addr  = 8'h07;
    tick(3);
    check("full_hold_cmd_ready", ifc.cmd_ready, 0);
    ifc.cmd_valid = 1'b0;
    ifc.ready     = 1'b1;
    wait_idle();
    check("full_drained", exp_cmds.size(), 0);
    check("full_cmd_ready_back", ifc.cmd_ready, 1);

    // Simultaneous push and pop with two queued entries.
    ifc.ready = 1'b0;
    push_cmd(1'b1, 8'h01, DW'($urandom));
    push_cmd(1'b1, 8'h02, DW'($urandom));
    push_cmd(1'b1, 8'h03, DW'($urandom));
    ifc.ready = 1'b1;
    tick(1);
    ifc.ready     = 1'b0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_wr    = 1'b1;
    ifc.cmd_addr  = 8'h04;
    ifc.cmd_wdata = DW'($urandom);
    check("simul_cmd_ready", ifc.cmd_ready, 1);
    tick(1);
    ifc.cmd_valid = 1'b0;
    check("simul_sel", ifc.sel, 1);
    push_cmd(1'b1, 8'h05, DW'($urandom));
    check("simul_after_e", ifc.cmd_ready, 1);
    push_cmd(1'b0, 8'h04, 16'h0);
    check("simul_after_f", ifc.cmd_ready, 0);
    ifc.ready = 1'b1;
    wait_idle();
    check("simul_drained", exp_cmds.size(), 0);

    // Random traffic with short stalls.
    rdy_mode = RDY_RAND;
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 7));
      d = DW'($urandom);
      push_cmd(w, a, d);
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
    end
    rdy_mode      = RDY_MANUAL;
    ifc.ready     = 1'b1;
    ifc.rsp_ready = 1'b1;
    wait_idle();
    check("rand_cmds_drained", exp_cmds.size(), 0);
    check("rand_rsps_drained", exp_rsps.size(), 0);
    check("rand_no_timeout", ifc.err_timeout, 0);

    // Read timeout while ready stays low for 20 cycles.
    ifc.ready     = 1'b0;
    ifc.rsp_ready = 1'b0;
    push_cmd(1'b0, 8'h05, 16'h0);
    n_sel = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ifc.sel) n_sel++;
    end
    check("to_sel_cycles", n_sel, TIMEOUT);
    check("to_err", ifc.err_timeout, 1);
    check("to_rsp_valid", ifc.rsp_valid, 1);
    check("to_rsp_err", ifc.rsp_err, 1);
    check("to_rsp_data", ifc.rsp_data, 0);
    check("to_rsp_addr", ifc.rsp_addr, 32'h05);
    ifc.rsp_ready = 1'b1;
    tick(1);
    check("to_rsp_done", ifc.rsp_valid, 0);
    ifc.ready = 1'b1;
    push_cmd(1'b1, 8'h06, 16'h5A5A);
    push_cmd(1'b0, 8'h06, 16'h0);
    wait_idle();
    check("to_next_drained", exp_rsps.size(), 0);
    check("to_err_sticky", ifc.err_timeout, 1);

    // Reset while a command sits in REQ with three queued behind it.
    ifc.ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, AW'(8'h20 + i), DW'($urandom));
    check("rstmid_pre_sel", ifc.sel, 1);
    rst = 1'b1;
    tick(1);
    check("rstmid_sel", ifc.sel, 0);
    check("rstmid_busy", ifc.busy, 0);
    check("rstmid_err", ifc.err_timeout, 0);
    check("rstmid_cmd_ready", ifc.cmd_ready, 1);
    rst       = 1'b0;
    ifc.ready = 1'b1;
    n_sel     = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (ifc.sel) n_sel++;
    end
    check("rstmid_no_bus", n_sel, 0);
    check("rstmid_busy_after", ifc.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
